// File: rtl/bip_pkg.sv
// bip_pkg: shared encodings for the BIP accumulator datapath
package bip_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    localparam logic [1:0] SEL_RAM  = 2'd0;
    localparam logic [1:0] SEL_IMM  = 2'd1;
    localparam logic [1:0] SEL_ALU  = 2'd2;
    localparam logic [1:0] SEL_HOLD = 2'd3;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;
endpackage

// File: rtl/bip_datapath_if.sv
// bip_datapath_if: program-memory/control and RAM signals of the datapath
interface bip_datapath_if #(
    parameter int E_BITS  = 16,
    parameter int D_BITS  = 11,
    parameter int S_BITS  = 2,
    parameter int OP_BITS = 3
);
    logic [D_BITS-1:0]  i_Data;
    logic [E_BITS-1:0]  i_Data_ram;
    logic               i_ram_valid;
    logic [S_BITS-1:0]  sel_A;
    logic               sel_B;
    logic [OP_BITS-1:0] i_op;
    logic               w_acc;
    logic               i_sext;
    logic [D_BITS-1:0]  o_Addr_ram;
    logic [E_BITS-1:0]  o_Data_ram;
    logic               o_busy;
    logic [3:0]         o_flags;
    logic               o_err;

    modport master (
        output i_Data, i_Data_ram, i_ram_valid, sel_A, sel_B, i_op, w_acc, i_sext,
        input  o_Addr_ram, o_Data_ram, o_busy, o_flags, o_err
    );
    modport slave (
        input  i_Data, i_Data_ram, i_ram_valid, sel_A, sel_B, i_op, w_acc, i_sext,
        output o_Addr_ram, o_Data_ram, o_busy, o_flags, o_err
    );
endinterface

// File: rtl/bip_alu.sv
// bip_alu: combinational ALU producing result and {N,Z,C,V}
module bip_alu
    import bip_pkg::*;
#(
    parameter int E_BITS  = 16,
    parameter int OP_BITS = 3
) (
    input  logic [E_BITS-1:0]  a,
    input  logic [E_BITS-1:0]  b,
    input  logic [OP_BITS-1:0] op,
    output logic [E_BITS-1:0]  r,
    output logic [3:0]         f
);
    localparam int SH = $clog2(E_BITS);

    logic [E_BITS:0]   sum;
    logic [E_BITS:0]   diff;
    logic [SH-1:0]     sh;
    logic              c;
    logic              v;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign sh   = b[SH-1:0];

    // result select; carry/overflow only meaningful for add/sub, else 0
    always_comb begin
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                r = sum[E_BITS-1:0];
                c = sum[E_BITS];
                v = (a[E_BITS-1] == b[E_BITS-1]) && (r[E_BITS-1] != a[E_BITS-1]);
            end
            OP_SUB: begin
                r = diff[E_BITS-1:0];
                c = diff[E_BITS];
                v = (a[E_BITS-1] != b[E_BITS-1]) && (r[E_BITS-1] != a[E_BITS-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            default: r = $signed(a) >>> sh;
        endcase
    end

    // pack flags by their named bit positions
    always_comb begin
        f         = '0;
        f[FLAG_N] = r[E_BITS-1];
        f[FLAG_Z] = ~|r;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
    end
endmodule

// File: rtl/bip_datapath.sv
// bip_datapath: accumulator datapath with RAM-wait FSM and timeout error
module bip_datapath
    import bip_pkg::*;
#(
    parameter int E_BITS  = 16,
    parameter int D_BITS  = 11,
    parameter int S_BITS  = 2,
    parameter int OP_BITS = 3,
    parameter int TIMEOUT = 8
) (
    input  logic            i_clock,
    input  logic            i_reset,
    bip_datapath_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t             state;
    logic [E_BITS-1:0]  acc;
    logic [3:0]         flags;
    logic               err;
    logic [CW-1:0]      cnt;
    logic [D_BITS-1:0]  cap_addr;
    logic [S_BITS-1:0]  cap_sel_a;
    logic               cap_sel_b;
    logic [OP_BITS-1:0] cap_op;
    logic               cap_sext;

    logic               idle;
    logic [D_BITS-1:0]  data_e;
    logic [S_BITS-1:0]  sel_a_e;
    logic               sel_b_e;
    logic [OP_BITS-1:0] op_e;
    logic               sext_e;
    logic [E_BITS-1:0]  imm;
    logic [E_BITS-1:0]  b_op;
    logic [E_BITS-1:0]  alu_r;
    logic [3:0]         alu_f;
    logic [E_BITS-1:0]  acc_nx;
    logic               need_ram;
    logic               do_write;

    // in WAIT the captured controls replace the live ones
    assign idle     = state == S_IDLE;
    assign data_e   = idle ? bus.i_Data : cap_addr;
    assign sel_a_e  = idle ? bus.sel_A  : cap_sel_a;
    assign sel_b_e  = idle ? bus.sel_B  : cap_sel_b;
    assign op_e     = idle ? bus.i_op   : cap_op;
    assign sext_e   = idle ? bus.i_sext : cap_sext;
    assign imm      = sext_e ? {{(E_BITS-D_BITS){data_e[D_BITS-1]}}, data_e}
                             : {{(E_BITS-D_BITS){1'b0}}, data_e};
    assign b_op     = sel_b_e ? imm : bus.i_Data_ram;
    assign acc_nx   = sel_a_e == SEL_RAM ? bus.i_Data_ram : sel_a_e == SEL_IMM ? imm : alu_r;
    assign need_ram = bus.sel_A == SEL_RAM || (bus.sel_A == SEL_ALU && !bus.sel_B);
    assign do_write = idle ? bus.w_acc && !need_ram && bus.sel_A != SEL_HOLD : bus.i_ram_valid;

    bip_alu #(.E_BITS(E_BITS), .OP_BITS(OP_BITS)) u_alu (
        .a  (acc),
        .b  (b_op),
        .op (op_e),
        .r  (alu_r),
        .f  (alu_f)
    );

    assign bus.o_Addr_ram = data_e;
    assign bus.o_Data_ram = acc;
    assign bus.o_busy     = state == S_WAIT;
    assign bus.o_flags    = flags;
    assign bus.o_err      = err;

    // accumulator/flag writes, RAM-wait FSM and timeout counter
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= S_IDLE;
            acc       <= '0;
            flags     <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_sel_a <= '0;
            cap_sel_b <= 1'b0;
            cap_op    <= '0;
            cap_sext  <= 1'b0;
        end else begin
            if (do_write) acc <= acc_nx;
            if (do_write && sel_a_e == SEL_ALU) flags <= alu_f;
            if (idle) begin
                if (bus.w_acc && need_ram) begin
                    state     <= S_WAIT;
                    cnt       <= '0;
                    cap_addr  <= bus.i_Data;
                    cap_sel_a <= bus.sel_A;
                    cap_sel_b <= bus.sel_B;
                    cap_op    <= bus.i_op;
                    cap_sext  <= bus.i_sext;
                end
            end else if (bus.i_ram_valid || cnt == LAST) begin
                state <= S_IDLE;
                err   <= err | !bus.i_ram_valid;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bip_datapath.sv
// tb_bip_datapath: directed and randomized checks against a behavioural model
module tb_bip_datapath;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   m_acc = 0;
    int   m_flags = 0;
    int   m_err = 0;

    always #5 clk = ~clk;

    bip_datapath_if #(.E_BITS(16), .D_BITS(11), .S_BITS(2), .OP_BITS(3)) bus ();

    bip_datapath #(.E_BITS(16), .D_BITS(11), .S_BITS(2), .OP_BITS(3), .TIMEOUT(8)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    function automatic int s16(int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    function automatic int ext_imm(int d, int sext);
        return (sext != 0 && d >= 1024) ? (d - 2048) & 16'hFFFF : d;
    endfunction

    // returns flags*65536 + result, computed arithmetically
    function automatic int alu_model(int a, int b, int op);
        int r;
        int c = 0;
        int v = 0;
        int sv;
        int sh = b % 16;
        case (op)
            0: begin r = (a + b) % 65536; c = (a + b) >= 65536 ? 1 : 0; sv = s16(a) + s16(b); v = (sv > 32767 || sv < -32768) ? 1 : 0; end
            1: begin r = (a - b + 65536) % 65536; c = a < b ? 1 : 0; sv = s16(a) - s16(b); v = (sv > 32767 || sv < -32768) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a << sh) & 16'hFFFF;
            6: r = a >> sh;
            default: r = (s16(a) >>> sh) & 16'hFFFF;
        endcase
        return ((r >= 32768 ? 8 : 0) + (r == 0 ? 4 : 0) + c * 2 + v) * 65536 + r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.i_Data = '0; bus.i_Data_ram = '0; bus.i_ram_valid = 1'b0; bus.sel_A = 2'd3;
        bus.sel_B = 1'b0; bus.i_op = '0; bus.w_acc = 1'b0; bus.i_sext = 1'b0;
    endtask

    // one instruction; delay = wait cycle on which valid rises (>8 means never)
    task automatic do_op(int sel_a, int sel_b, int op, int d, int sext, int delay, int ramval);
        int need = (sel_a == 0 || (sel_a == 2 && sel_b == 0)) ? 1 : 0;
        int b;
        int res;
        bus.sel_A = 2'(sel_a); bus.sel_B = 1'(sel_b); bus.i_op = 3'(op);
        bus.i_Data = 11'(d); bus.i_sext = 1'(sext); bus.w_acc = 1'b1;
        bus.i_ram_valid = 1'($urandom_range(1)); bus.i_Data_ram = 16'($urandom);
        step();
        if (need == 0) begin
            b = sel_b != 0 ? ext_imm(d, sext) : 0;
            res = alu_model(m_acc, b, op);
            if (sel_a == 1) m_acc = ext_imm(d, sext);
            if (sel_a == 2) begin m_acc = res % 65536; m_flags = res / 65536; end
            idle_inputs();
        end else begin
            for (int k = 1; k <= 8 && k <= delay; k++) begin
                total++;
                if (bus.o_busy !== 1'b1 || bus.o_Addr_ram !== 11'(d)) $display("FAIL wait_busy_addr cycle %0d busy=%b addr=%0d exp busy=1 addr=%0d", k, bus.o_busy, bus.o_Addr_ram, d);
                else passed++;
                bus.sel_A = 2'($urandom); bus.sel_B = 1'($urandom); bus.i_op = 3'($urandom);
                bus.i_Data = 11'($urandom); bus.i_sext = 1'($urandom); bus.w_acc = 1'($urandom);
                bus.i_ram_valid = 1'(k == delay);
                bus.i_Data_ram = (k == delay) ? 16'(ramval) : 16'($urandom);
                step();
            end
            idle_inputs();
            if (delay > 8) m_err = 1;
            else if (sel_a == 0) m_acc = ramval;
            else begin
                res = alu_model(m_acc, ramval, op);
                m_acc = res % 65536;
                m_flags = res / 65536;
            end
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        bus.sel_A = 2'd1; bus.i_Data = 11'd5;
        for (int i = 0; i < 4; i++) begin
            bus.w_acc = 1'(i % 2 == 0);
            step();
        end
        total++;
        if (bus.o_Data_ram !== 16'h0 || bus.o_flags !== 4'h0 || bus.o_busy !== 1'b0 || bus.o_err !== 1'b0)
            $display("FAIL reset acc=%h flags=%h busy=%b err=%b exp all zero", bus.o_Data_ram, bus.o_flags, bus.o_busy, bus.o_err);
        else passed++;
        idle_inputs();
        rst_n = 1'b1;
        m_acc = 0; m_flags = 0; m_err = 0;
        step();
    endtask

    task automatic test_ldi;
        bus.sel_A = 2'd1; bus.i_Data = 11'd3; bus.w_acc = 1'b1;
        step();
        idle_inputs();
        total++;
        if (bus.o_Data_ram !== 16'h0003 || bus.o_busy !== 1'b0 || bus.o_flags !== 4'h0)
            $display("FAIL ldi acc=%h busy=%b flags=%h exp 0003/0/0", bus.o_Data_ram, bus.o_busy, bus.o_flags);
        else passed++;
        m_acc = 3;
    endtask

    task automatic test_ld;
        bus.sel_A = 2'd0; bus.i_Data = 11'd2; bus.w_acc = 1'b1;
        bus.i_ram_valid = 1'b1; bus.i_Data_ram = 16'h0055;
        step();
        bus.w_acc = 1'b0; bus.i_Data = 11'd5; bus.i_ram_valid = 1'b0;
        total++;
        if (bus.o_busy !== 1'b1 || bus.o_Addr_ram !== 11'd2 || bus.o_Data_ram !== 16'h0003)
            $display("FAIL ld_wait1 busy=%b addr=%0d acc=%h exp 1/2/0003", bus.o_busy, bus.o_Addr_ram, bus.o_Data_ram);
        else passed++;
        step();
        total++;
        if (bus.o_busy !== 1'b1 || bus.o_Addr_ram !== 11'd2 || bus.o_Data_ram !== 16'h0003)
            $display("FAIL ld_wait2 busy=%b addr=%0d acc=%h exp 1/2/0003", bus.o_busy, bus.o_Addr_ram, bus.o_Data_ram);
        else passed++;
        bus.i_ram_valid = 1'b1; bus.i_Data_ram = 16'h0001;
        step();
        bus.i_ram_valid = 1'b0;
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_Data_ram !== 16'h0001 || bus.o_Addr_ram !== 11'd5 || bus.o_flags !== 4'h0)
            $display("FAIL ld_done busy=%b acc=%h addr=%0d flags=%h exp 0/0001/5/0", bus.o_busy, bus.o_Data_ram, bus.o_Addr_ram, bus.o_flags);
        else passed++;
        idle_inputs();
        m_acc = 1;
    endtask

    task automatic test_addi;
        do_op(2, 1, 0, 11'h7FF, 1, 0, 0);
        total++;
        if (bus.o_Data_ram !== 16'h0000 || bus.o_flags !== 4'b0110)
            $display("FAIL addi acc=%h flags=%b exp 0000/0110", bus.o_Data_ram, bus.o_flags);
        else passed++;
    endtask

    task automatic test_subi_sra;
        do_op(0, 0, 0, 7, 0, 1, 16'h8000);
        do_op(2, 1, 1, 1, 0, 0, 0);
        total++;
        if (bus.o_Data_ram !== 16'h7FFF || bus.o_flags !== 4'b0001)
            $display("FAIL subi acc=%h flags=%b exp 7fff/0001", bus.o_Data_ram, bus.o_flags);
        else passed++;
        do_op(0, 0, 0, 7, 0, 3, 16'h8000);
        total++;
        if (bus.o_Data_ram !== 16'h8000 || bus.o_flags !== 4'b0001)
            $display("FAIL ld_keeps_flags acc=%h flags=%b exp 8000/0001", bus.o_Data_ram, bus.o_flags);
        else passed++;
        do_op(2, 1, 7, 4, 0, 0, 0);
        total++;
        if (bus.o_Data_ram !== 16'hF800 || bus.o_flags !== 4'b1000)
            $display("FAIL sra acc=%h flags=%b exp f800/1000", bus.o_Data_ram, bus.o_flags);
        else passed++;
        do_op(3, 0, 0, 9, 0, 0, 0);
        total++;
        if (bus.o_Data_ram !== 16'hF800 || bus.o_flags !== 4'b1000 || bus.o_busy !== 1'b0)
            $display("FAIL hold acc=%h flags=%b busy=%b exp f800/1000/0", bus.o_Data_ram, bus.o_flags, bus.o_busy);
        else passed++;
    endtask

    task automatic test_valid_last_cycle;
        do_op(0, 0, 0, 33, 0, 8, 16'h1234);
        total++;
        if (bus.o_Data_ram !== 16'h1234 || bus.o_err !== 1'b0 || bus.o_busy !== 1'b0)
            $display("FAIL valid_on_last acc=%h err=%b busy=%b exp 1234/0/0", bus.o_Data_ram, bus.o_err, bus.o_busy);
        else passed++;
    endtask

    task automatic test_timeout;
        int busy_cycles = 0;
        bus.sel_A = 2'd0; bus.i_Data = 11'd9; bus.w_acc = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 20 && bus.o_busy === 1'b1; i++) begin
            busy_cycles++;
            step();
        end
        total++;
        if (busy_cycles != 8) $display("FAIL timeout_busy_cycles got %0d exp 8", busy_cycles);
        else passed++;
        total++;
        if (bus.o_Data_ram !== 16'h1234 || bus.o_err !== 1'b1 || bus.o_flags !== 4'b1000)
            $display("FAIL timeout_state acc=%h err=%b flags=%b exp 1234/1/1000", bus.o_Data_ram, bus.o_err, bus.o_flags);
        else passed++;
        do_op(1, 0, 0, 4, 0, 0, 0);
        do_op(0, 0, 0, 4, 0, 2, 16'h00AA);
        total++;
        if (bus.o_err !== 1'b1 || bus.o_Data_ram !== 16'h00AA)
            $display("FAIL err_sticky err=%b acc=%h exp 1/00aa", bus.o_err, bus.o_Data_ram);
        else passed++;
        bus.sel_A = 2'd0; bus.i_Data = 11'd9; bus.w_acc = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        bus.i_ram_valid = 1'b1; bus.i_Data_ram = 16'h7777;
        rst_n = 1'b0;
        #2;
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_err !== 1'b0 || bus.o_Data_ram !== 16'h0 || bus.o_flags !== 4'h0)
            $display("FAIL reset_mid_wait busy=%b err=%b acc=%h flags=%h exp 0/0/0000/0", bus.o_busy, bus.o_err, bus.o_Data_ram, bus.o_flags);
        else passed++;
        step();
        idle_inputs();
        rst_n = 1'b1;
        m_acc = 0; m_flags = 0; m_err = 0;
        step();
    endtask

    task automatic test_random;
        for (int n = 0; n < 300; n++) begin
            int sa = $urandom_range(3);
            int sb = $urandom_range(1);
            int dl = (sa == 0 || (sa == 2 && sb == 0)) ? $urandom_range(1, 10) : 0;
            do_op(sa, sb, $urandom_range(7), $urandom_range(2047), $urandom_range(1), dl, $urandom_range(65535));
            total++;
            if (bus.o_Data_ram !== 16'(m_acc) || bus.o_flags !== 4'(m_flags) || bus.o_err !== 1'(m_err) || bus.o_busy !== 1'b0)
                $display("FAIL random_%0d acc=%h flags=%b err=%b busy=%b exp %h/%b/%0d/0", n, bus.o_Data_ram, bus.o_flags, bus.o_err, bus.o_busy, 16'(m_acc), 4'(m_flags), m_err);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_ld();
        test_addi();
        test_subi_sra();
        test_valid_last_cycle();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bip_datapath.md
BIP_DATAPATH -- requirements
Module: bip_datapath

Interface
REQ-001 SHALL have parameters: E_BITS, 16, data/accumulator width; D_BITS, 11, operand/address width; S_BITS, 2, sel_A width; OP_BITS, 3, ALU opcode width; TIMEOUT, 8, maximum cycles to wait for RAM data.
REQ-002 SHALL have ports as listed below.
- i_clock  in  1  sole clock; all state changes on its rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_Data  in  D_BITS  operand field from program memory: immediate or RAM address.
- i_Data_ram  in  E_BITS  RAM read data.
- i_ram_valid  in  1  i_Data_ram valid this cycle.
- sel_A  in  S_BITS  accumulator source: 0 RAM, 1 immediate, 2 ALU result, 3 hold.
- sel_B  in  1  ALU operand B: 0 RAM, 1 immediate.
- i_op  in  OP_BITS  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
- w_acc  in  1  accumulator write request.
- i_sext  in  1  immediate sign-extended (1) or zero-extended (0) to E_BITS.
- o_Addr_ram  out  D_BITS  RAM address.
- o_Data_ram  out  E_BITS  accumulator value (RAM write data).
- o_busy  out  1  waiting for RAM data.
- o_flags  out  4  {N,Z,C,V}.
- o_err  out  1  sticky RAM-timeout error.

Function
REQ-003 ALU operand A SHALL be the accumulator; operand B SHALL be i_Data_ram or the extended immediate, per sel_B.
REQ-004 ADD/SUB SHALL be E_BITS wide modulo 2^E_BITS, with C = carry-out for ADD and C = borrow for SUB, and V = signed overflow.
REQ-005 Shifts SHALL shift by operand B[$clog2(E_BITS)-1:0]; SRA SHALL replicate the MSB.
REQ-006 For logic and shift ops, C and V SHALL be written 0.
REQ-007 N and Z SHALL derive from the result written to the accumulator.
REQ-008 Flags SHALL update only on an accumulator write with sel_A=2; otherwise flags SHALL hold.
REQ-009 The FSM SHALL have two states, IDLE and WAIT.
REQ-010 In IDLE, a write (w_acc=1) that needs no RAM data (sel_A=1, or sel_A=2 with sel_B=1) SHALL update the accumulator on the same rising edge; no-RAM latency = 1 cycle.
REQ-011 In IDLE, a write that needs RAM data (sel_A=0, or sel_A=2 with sel_B=0) SHALL perform IDLE->WAIT on that edge, capturing i_Data, sel_A, sel_B, i_op and i_sext.
REQ-012 A write with sel_A=3 SHALL leave the accumulator and flags unchanged.
REQ-013 In WAIT, o_busy SHALL be 1 and o_Addr_ram SHALL equal the captured address.
REQ-014 In IDLE, o_Addr_ram SHALL equal i_Data combinationally.
REQ-015 In WAIT, i_ram_valid=1 SHALL write the accumulator (and flags if ALU) using captured controls and the current i_Data_ram, then perform WAIT->IDLE.
REQ-016 Minimum RAM-load latency SHALL be 2 edges (request edge plus valid edge).
REQ-017 i_ram_valid SHALL be ignored in IDLE.
REQ-018 All control inputs SHALL be ignored in WAIT.
REQ-019 A wait counter SHALL count cycles in WAIT; if TIMEOUT cycles elapse without valid, the block SHALL return to IDLE with the accumulator and flags unchanged and SHALL set o_err.
REQ-020 If valid arrives on the TIMEOUT-th cycle, valid SHALL win and o_err SHALL stay unchanged.
REQ-021 o_Data_ram SHALL always equal the registered accumulator.

Reset
REQ-022 i_reset=0 SHALL immediately force accumulator=0, flags=0, state=IDLE, wait counter=0, o_busy=0, o_err=0, captured controls=0.
REQ-023 Reset asserted mid-WAIT SHALL abort the pending load with no accumulator write.
REQ-024 o_err SHALL clear only by reset.

Structure
REQ-025 A shared package bip_pkg SHALL hold the opcode encodings, sel_A encodings, flag bit indices and the FSM state type.
REQ-026 A combinational sub-module bip_alu SHALL compute result and flags from (A, B, op); the accumulator, flags, FSM and counter SHALL reside in bip_datapath.

Verification
REQ-027 Reset: i_reset=0 with w_acc toggling -> o_Data_ram=0, o_flags=0, o_busy=0, o_err=0.
REQ-028 LDI 3: sel_A=1, i_Data=3, w_acc=1 -> o_Data_ram=0x0003 after one edge, o_busy never 1, flags unchanged.
REQ-029 LD 2, valid 2 cycles after request, i_Data_ram=0x0001, i_Data changed to 5 during WAIT -> o_Addr_ram=2 throughout WAIT, o_busy=1 for 2 cycles, o_Data_ram=0x0001.
REQ-030 ADDI sign-extended: ACC=0x0001, i_Data=0x7FF, i_sext=1, sel_A=2, sel_B=1, op=ADD -> ACC=0x0000, flags Z=1, C=1, V=0, N=0.
REQ-031 SUBI 1 with ACC=0x8000 -> ACC=0x7FFF, V=1, N=0, C=0; then SRA by 4 with ACC=0x8000 -> ACC=0xF800, N=1.
REQ-032 LD with i_ram_valid held 0 -> o_busy drops after 8 cycles, ACC unchanged, o_err=1 until reset; a repeat with reset asserted on wait cycle 3 -> IDLE, o_err=0.
